unary_matmul_sequencer: RTL

Sequencer for the unary-binary systolic matmul array. It accepts one job per start handshake and generates all per-cycle control for one matrix product:
- the unary window counter that drives the A comparators;
- the window-boundary strobe (data_clk role);
- the skewed A-row select per column;
- the per-element C capture strobes;
- a done handshake.

It sits between the host-side job interface and the datapath (comparators, node array, C capture registers) and carries no operand data itself.

---
 rtl/unary_matmul_sequencer_pkg.sv | 27 ++
 rtl/unary_matmul_sequencer_if.sv | 19 +
 rtl/unary_matmul_sequencer_window_counter.sv | 40 ++++
 rtl/unary_matmul_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/unary_matmul_sequencer_pkg.sv
// Shared types and sizing helpers for the unary-binary matmul sequencer.
// Window length is 2^SIZE + 2 cycles; one window per skew step.
package unary_mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int win_len(input int size);
        return (1 << size) + 2;
    endfunction

    function automatic int num_steps(input int a_row, input int a_col, input int b_col);
        return a_row + a_col + b_col;
    endfunction

    function automatic int step_width(input int steps);
        return $clog2(steps + 1);
    endfunction

    function automatic int row_width(input int rows);
        return $clog2(rows + 1);
    endfunction

endpackage

// File: rtl/unary_matmul_sequencer_if.sv
// Host-side job handshake: start request, abort, completion handshake and busy flag.
interface unary_matmul_sequencer_if;
    logic start_valid;
    logic start_ready;
    logic abort;
    logic busy;
    logic done_valid;
    logic done_ready;

    modport master (
        output start_valid, abort, done_ready,
        input  start_ready, busy, done_valid
    );

    modport slave (
        input  start_valid, abort, done_ready,
        output start_ready, busy, done_valid
    );
endinterface

// File: rtl/unary_matmul_sequencer_window_counter.sv
// Unary window counter: counts 0..W-1 while enabled and flags the last cycle of each window.
module unary_window_counter
    import unary_mm_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          en,
    output logic [SIZE:0] win_cnt,
    output logic          wrap
);
    localparam int W = win_len(SIZE);
    localparam logic [SIZE:0] LAST = (SIZE + 1)'(W - 1);
    localparam logic [SIZE:0] ONE  = (SIZE + 1)'(1);

    logic [SIZE:0] cnt_reg;
    logic [SIZE:0] cnt_next;

    assign wrap    = en && (cnt_reg == LAST);
    assign win_cnt = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear || wrap) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/unary_matmul_sequencer.sv
// Job sequencer for the systolic unary matmul array: window counting, skewed A-row
// selects, C capture strobes and the start/done handshake. Carries no operand data.
module unary_matmul_sequencer
    import unary_mm_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int A_ROW = 2,
    parameter int A_COL = 2,
    parameter int B_COL = 2,
    localparam int NUM_STEPS = num_steps(A_ROW, A_COL, B_COL),
    localparam int STEP_W    = step_width(NUM_STEPS),
    localparam int ROW_W     = row_width(A_ROW)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    unary_matmul_sequencer_if.slave           host,
    output logic                              acc_clear,
    output logic [SIZE:0]                     win_cnt,
    output logic                              win_first,
    output logic [STEP_W-1:0]                 step,
    output logic [A_COL-1:0]                  a_en,
    output logic [A_COL-1:0][ROW_W-1:0]       a_row,
    output logic [A_ROW*B_COL-1:0]            cap_mask
);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] ROWS      = STEP_W'(A_ROW);

    state_t            state_reg, state_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic              run;
    logic              wrap;
    logic              cnt_clear;

    assign run       = (state_reg == RUN);
    assign cnt_clear = !run || host.abort;

    unary_window_counter #(.SIZE(SIZE)) u_window (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .en      (run),
        .win_cnt (win_cnt),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    // abort outranks both the last-window exit and the done handshake
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        acc_clear  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (host.start_valid) begin
                    state_next = RUN;
                    step_next  = '0;
                    acc_clear  = 1'b1;
                end
            end
            RUN: begin
                if (host.abort) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else if (wrap) begin
                    if (step_reg == LAST_STEP) begin
                        state_next = DONE;
                        step_next  = '0;
                    end else begin
                        step_next = step_reg + STEP_ONE;
                    end
                end
            end
            DONE: begin
                if (host.abort || host.done_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
            end
        endcase
    end

    assign host.start_ready = (state_reg == IDLE);
    assign host.busy        = run;
    assign host.done_valid  = (state_reg == DONE);
    assign win_first        = run && (win_cnt == '0);
    assign step             = step_reg;

    genvar gi, gj;

    // Column j is fed A rows with a j-window skew; subtract only once step>=j
    for (gi = 0; gi < A_COL; gi++) begin : g_skew
        localparam logic [STEP_W-1:0] COL = STEP_W'(gi);
        logic [STEP_W-1:0] diff;
        logic              en_bit;
        logic [ROW_W-1:0]  row_val;

        always_comb begin
            diff    = '0;
            en_bit  = 1'b0;
            row_val = '0;
            if (run && (step_reg >= COL)) begin
                diff = step_reg - COL;
                if (diff < ROWS) begin
                    en_bit  = 1'b1;
                    row_val = ROW_W'(diff);
                end
            end
        end

        assign a_en[gi]  = en_bit;
        assign a_row[gi] = row_val;
    end

    // C[m][n] has drained out of the array once the skewed wavefront passes it
    for (gi = 0; gi < A_ROW; gi++) begin : g_cap_row
        for (gj = 0; gj < B_COL; gj++) begin : g_cap_col
            assign cap_mask[gi*B_COL+gj] = win_first && (step_reg == STEP_W'(gi + gj + A_COL + 1));
        end
    end
endmodule
